// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the pipelined CLA adder/subtractor
// Contents: op_t operation encoding, SLICE_W slice width, sat_word() saturation constants.
package cla_pkg;

    typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, ADC = 2'd2, SBB = 2'd3} op_t;

    localparam int SLICE_W   = 4;
    localparam int SAT_MAX_W = 256;

    // Clamp value for a w-bit signed result: most negative when neg, else most positive.
    function automatic logic [SAT_MAX_W-1:0] sat_word(input logic neg, input int w);
        logic [SAT_MAX_W-1:0] m;
        m = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
        return neg ? m : m - 1'b1;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice
// Ports: x, y (4-bit operands), cin (carry in) -> s (4-bit sum), c3 (carry into bit 3), c4 (carry out).
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);

    logic [3:0] g, p;
    logic       c1, c2;

    assign g  = x & y;
    assign p  = x ^ y;
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s  = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined two's-complement add/sub built from 4-bit CLA slices
// Ports: clk, rst (async, active high); in_valid/in_ready, in_op (ADD/SUB/ADC/SBB), in_cin, in_x, in_y;
//        out_valid/out_ready, out_s, out_cout (raw carry), out_ovf (signed overflow), out_zero (out_s == 0).
// Build option: define SATURATE_EN to clamp out_s to the signed range on overflow.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CW  = SLICE_W * SLICES_PER_STAGE;
    localparam int NST = WIDTH / CW;

    op_t              op;
    logic             advance;
    logic [WIDTH-1:0] y_in;
    logic             c_in;

    // Stage inputs (index 0 is the prepared input beat, k>0 is the register of stage k-1)
    logic             sv [NST];
    logic [WIDTH-1:0] sx [NST];
    logic [WIDTH-1:0] sy [NST];
    logic [WIDTH-1:0] ss [NST];
    logic             sc [NST];

    // Stage registers; the last one is the output register
    logic             rv [NST];
    logic [WIDTH-1:0] rx [NST];
    logic [WIDTH-1:0] ry [NST];
    logic [WIDTH-1:0] rs [NST];
    logic             rc [NST];
    logic             ovf_r;

    logic [NST-1:0][SLICES_PER_STAGE:0]   cc;
    logic [NST-1:0][CW-1:0]               chunk;
    logic [NST-1:0][SLICES_PER_STAGE-1:0] c3;
    logic [WIDTH-1:0]                     ns [NST];

    assign op       = op_t'(in_op);
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign y_in     = (op == SUB || op == SBB) ? ~in_y : in_y;
    // SBB treats in_cin as a borrow, so the adder carry-in is its inverse
    assign c_in     = op == ADD ? 1'b0 : op == SUB ? 1'b1 : op == ADC ? in_cin : ~in_cin;

    always_comb begin
        sv[0] = in_valid;
        sx[0] = in_x;
        sy[0] = y_in;
        ss[0] = '0;
        sc[0] = c_in;
        for (int k = 1; k < NST; k++) begin
            sv[k] = rv[k-1];
            sx[k] = rx[k-1];
            sy[k] = ry[k-1];
            ss[k] = rs[k-1];
            sc[k] = rc[k-1];
        end
    end

    // Each stage splices its freshly computed chunk into the partial sum carried along
    always_comb begin
        for (int k = 0; k < NST; k++) begin
            ns[k]              = ss[k];
            ns[k][k*CW +: CW]  = chunk[k];
        end
    end

    for (genvar k = 0; k < NST; k++) begin : g_st
        assign cc[k][0] = sc[k];
        for (genvar j = 0; j < SLICES_PER_STAGE; j++) begin : g_sl
            cla4_slice u_sl (
                .x   (sx[k][k*CW + j*SLICE_W +: SLICE_W]),
                .y   (sy[k][k*CW + j*SLICE_W +: SLICE_W]),
                .cin (cc[k][j]),
                .s   (chunk[k][j*SLICE_W +: SLICE_W]),
                .c3  (c3[k][j]),
                .c4  (cc[k][j+1])
            );
        end
    end

    // Data registers load only for valid beats so bubbles never disturb out_s
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NST; k++) begin
                rv[k] <= 1'b0;
                rx[k] <= '0;
                ry[k] <= '0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NST; k++) begin
                rv[k] <= sv[k];
                if (sv[k]) begin
                    rx[k] <= sx[k];
                    ry[k] <= sy[k];
                    rs[k] <= ns[k];
                    rc[k] <= cc[k][SLICES_PER_STAGE];
                end
            end
            if (sv[NST-1])
                ovf_r <= c3[NST-1][SLICES_PER_STAGE-1] ^ cc[NST-1][SLICES_PER_STAGE];
        end
    end

    assign out_valid = rv[NST-1];
    assign out_cout  = rc[NST-1];
    assign out_ovf   = ovf_r;

`ifdef SATURATE_EN
    logic [SAT_MAX_W-1:0] sat;
    // The sign of x gives the direction of the true result when overflow occurred
    assign sat   = sat_word(rx[NST-1][WIDTH-1], WIDTH);
    assign out_s = ovf_r ? sat[WIDTH-1:0] : rs[NST-1];
`else
    assign out_s = rs[NST-1];
`endif

    assign out_zero = out_s == '0;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: self-checking bench for cla_addsub_pipe (WIDTH=16, one slice per stage)
module tb_cla_addsub_pipe;
    import cla_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 1, in_cin = 0;
    logic [1:0]   in_op = 0;
    logic [W-1:0] in_x = 0, in_y = 0;
    logic         in_ready, out_valid, out_cout, out_ovf, out_zero;
    logic [W-1:0] out_s;

    cla_addsub_pipe #(.WIDTH(W), .SLICES_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_cin(in_cin), .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         cout, ovf, zero;
        int           acc_cyc, acc_hold;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           cyc = 0, holds = 0, passed = 0, total = 0;
    logic [W-1:0] s0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic exp_t model(logic [1:0] op, logic cin, logic [W-1:0] x, logic [W-1:0] y);
        exp_t r;
        int ux = x, uy = y, sx = $signed(x), sy = $signed(y);
        int c = op[1] ? int'(cin) : 0;
        int u, sr;
        if (!op[0]) begin
            u = ux + uy + c;
            sr = sx + sy + c;
            r.cout = u > (1 << W) - 1;
        end else begin
            u = ux - uy - c;
            sr = sx - sy - c;
            r.cout = u >= 0;
        end
        r.ovf = sr > (1 << (W-1)) - 1 || sr < -(1 << (W-1));
        r.s = u[W-1:0];
`ifdef SATURATE_EN
        if (r.ovf) r.s = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        r.zero = r.s == 0;
        r.acc_cyc = 0;
        r.acc_hold = 0;
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        int k = $urandom_range(0, 7);
        return k == 0 ? 16'h0000 : k == 1 ? 16'hFFFF : k == 2 ? 16'h7FFF : k == 3 ? 16'h8000 :
               k == 4 ? 16'h0001 : W'($urandom);
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: record accepted beats, compare consumed ones in order with latency
    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            if (!in_ready) holds++;
            if (out_valid && out_ready) begin
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("s", out_s, e.s);
                    chk("cout", out_cout, e.cout);
                    chk("ovf", out_ovf, e.ovf);
                    chk("zero", out_zero, e.zero);
                    chk("latency", cyc - e.acc_cyc, LAT + holds - e.acc_hold);
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_op, in_cin, in_x, in_y);
                e.acc_cyc = cyc;
                e.acc_hold = holds;
                q.push_back(e);
            end
        end
    end

    task automatic send(logic [1:0] op, logic c, logic [W-1:0] x, logic [W-1:0] y);
        int i = 0;
        in_valid = 1; in_op = op; in_cin = c; in_x = x; in_y = y;
        @(negedge clk);
        while (!in_ready && i < 50) begin
            i++;
            @(negedge clk);
        end
        if (i == 50) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("out_valid_seen", out_valid, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_s", out_s, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_zero", out_zero, 1);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        send(ADD, 0, 16'h7FFF, 16'h0001);
        wait_out();
`ifdef SATURATE_EN
        chk("add_ovf_s", out_s, 16'h7FFF);
`else
        chk("add_ovf_s", out_s, 16'h8000);
`endif
        chk("add_ovf_flag", out_ovf, 1);
        chk("add_ovf_cout", out_cout, 0);
        chk("add_ovf_zero", out_zero, 0);
        @(posedge clk);
        #1;
        send(SUB, 0, 16'h0000, 16'h0001);
        send(SUB, 0, 16'h8000, 16'h0001);
        send(ADC, 1, 16'hFFFF, 16'h0000);
        send(SBB, 1, 16'h0005, 16'h0003);
        for (int i = 0; i < 8; i++) send(2'(i), 1'($urandom), pick(), pick());
        repeat (8) @(posedge clk);
        #1 out_ready = 0;
        for (int i = 0; i < 4; i++) send(ADD, 0, 16'(i * 16'h1111), 16'h0101);
        in_valid = 1; in_op = SUB; in_cin = 0; in_x = 16'h1234; in_y = 16'h0234;
        @(negedge clk);
        s0 = out_s;
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_s_stable", out_s, s0);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1;
        send(SUB, 0, 16'h1234, 16'h0234);
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(ADD, 0, pick(), pick());
        rst = 1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_s", out_s, 0);
        chk("midrst_zero", out_zero, 1);
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_beat", out_valid, 0);
        end
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_op = 2'($urandom);
            in_cin = 1'($urandom);
            in_x = pick();
            in_y = pick();
        end
        @(posedge clk);
        #1 in_valid = 0;
        out_ready = 1;
        repeat (12) @(negedge clk);
        chk("drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
